// File: rtl/spi_cfg_seq_pkg.sv
// Shared definitions for the SPI configuration sequencer: word width,
// default run parameters and the sequencer state encoding.
package spi_cfg_seq_pkg;

    localparam int WORD_W         = 16;
    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_GAP_CYCLES = 4;
    localparam int DEF_TIMEOUT    = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        FIN,
        ERR
    } state_t;

endpackage

// File: rtl/spi_cfg_rom.sv
// Fixed configuration table streamed to the SPI device, one word per address.
module spi_cfg_rom
    import spi_cfg_seq_pkg::*;
(
    input  logic [3:0]        addr,
    output logic [WORD_W-1:0] word
);

    // Plain combinational lookup; the sequencer registers the result
    always_comb begin
        word = 16'h0000;
        case (addr)
            4'd0:    word = 16'hA8AA;
            4'd1:    word = 16'h1234;
            4'd2:    word = 16'h5678;
            4'd3:    word = 16'h9ABC;
            4'd4:    word = 16'hDEF0;
            4'd5:    word = 16'h0F1E;
            4'd6:    word = 16'h2D3C;
            4'd7:    word = 16'h4B5A;
            4'd8:    word = 16'h6978;
            4'd9:    word = 16'h8796;
            4'd10:   word = 16'hA5B4;
            4'd11:   word = 16'hC3D2;
            4'd12:   word = 16'hE1F0;
            4'd13:   word = 16'h1357;
            4'd14:   word = 16'h2468;
            default: word = 16'hFFFF;
        endcase
    end

endmodule

// File: rtl/spi_cfg_seq.sv
// Configuration sequencer: on start, pushes NUM_REGS table words through the
// spi_write GO/ORDY handshake, with an idle gap between writes and a timeout
// on each handshake phase that aborts the run with a sticky error flag.
module spi_cfg_seq
    import spi_cfg_seq_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    output logic [WORD_W-1:0] regdata,
    output logic              GO,
    input  logic              ORDY,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        idx
);

    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t            state;
    logic [TW-1:0]     tcnt;
    logic [7:0]        gcnt;
    logic [WORD_W-1:0] rom_word;

    spi_cfg_rom u_rom (
        .addr (idx),
        .word (rom_word)
    );

    // Sequencer FSM; GO and done default low so each is a single-cycle pulse
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            regdata <= '0;
            GO      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            idx     <= '0;
            tcnt    <= '0;
            gcnt    <= '0;
        end else begin
            GO   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && ORDY) begin
                        state <= LOAD;
                        idx   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    regdata <= rom_word;
                    GO      <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!ORDY) begin
                        tcnt  <= '0;
                        state <= WAIT_DONE;
                    end else if (tcnt == TMO_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        tcnt <= tcnt + TMO_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (ORDY) begin
                        tcnt <= '0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else if (GAP_CYCLES == 0) begin
                            idx   <= idx + 4'd1;
                            state <= LOAD;
                        end else begin
                            gcnt  <= '0;
                            state <= GAP;
                        end
                    end else if (tcnt == TMO_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        tcnt <= tcnt + TMO_ONE;
                    end
                end
                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt  <= '0;
                        idx   <= idx + 4'd1;
                        state <= LOAD;
                    end else begin
                        gcnt <= gcnt + 8'd1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Self-checking bench for spi_cfg_seq. Each run is described by per-word
// spi_write behaviour (cycles until ORDY drops, cycles ORDY stays low); the
// expected GO/done/error timeline is derived from those numbers with plain
// arithmetic and compared against the DUT every cycle.
module tb_spi_cfg_seq;

    localparam int NREG = 8;
    localparam int GAP  = 4;
    localparam int TMO  = 1024;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] regdata;
    logic        GO;
    logic        ORDY;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  idx;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [15:0] romModel [16] = '{16'hA8AA, 16'h1234, 16'h5678, 16'h9ABC,
                                   16'hDEF0, 16'h0F1E, 16'h2D3C, 16'h4B5A,
                                   16'h6978, 16'h8796, 16'hA5B4, 16'hC3D2,
                                   16'hE1F0, 16'h1357, 16'h2468, 16'hFFFF};

    logic [15:0] modelReg;
    logic [3:0]  modelIdx;
    logic        modelErr;

    // hangKind: 0 none, 1 ORDY never drops, 2 ORDY never returns,
    // 3 ORDY drops exactly at the timeout limit, 4 ORDY returns exactly at the limit
    typedef struct {
        string name;
        int    dly;
        int    len;
        int    hangWord;
        int    hangKind;
        bit    extraStarts;
        int    expGo;
        int    expDone;
        int    expErr;
        int    expIdx;
    } vector_t;

    vector_t vectors [7];

    spi_cfg_seq #(
        .NUM_REGS   (NREG),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .regdata (regdata),
        .GO      (GO),
        .ORDY    (ORDY),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .idx     (idx)
    );

    // Free-running system clock
    always #5 CLK = ~CLK;

    function automatic logic [23:0] packOut(logic g, logic b, logic d, logic e,
                                            logic [3:0] i, logic [15:0] r);
        return {g, b, d, e, i, r};
    endfunction

    function automatic logic [23:0] curOut();
        return packOut(GO, busy, done, err, idx, regdata);
    endfunction

    task automatic checkOutput(input string name, input logic [23:0] actual,
                               input logic [23:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs for the next edge, then sample just after that edge
    task automatic applyStimulus(input logic s, input logic o);
        start = s;
        ORDY  = o;
        @(posedge CLK);
        #1;
    endtask

    // One run from an accepted start. Time t counts samples after the edge
    // that accepts start (t = 0).
    task automatic runSequence(input string name, input int ackDly[16], input int busyLen[16],
                               input bit extraStarts, input int abortWord,
                               output int goSeen, output int doneSeen,
                               output logic errEnd, output logic [3:0] idxEnd);
        int gTime [16];
        int aTime [16];
        int eTime [16];
        int nIssued, errT, doneT, endT, tEnd, abortT, lowEnd;
        logic ordyV [];
        logic startV [];
        logic expGo;
        logic [3:0]  expIdx;
        logic [15:0] expReg;

        errT = -1; doneT = -1; nIssued = 0; abortT = -1;
        for (int w = 0; w < 16; w++) begin
            gTime[w] = -1; aTime[w] = -1; eTime[w] = -1;
        end
        for (int w = 0; w < NREG; w++) begin
            if (w == 0) gTime[w] = 1;
            else        gTime[w] = eTime[w-1] + GAP + 1;
            nIssued = w + 1;
            if (ackDly[w] < 1 || ackDly[w] > TMO) begin
                errT = gTime[w] + TMO + 1;
                break;
            end
            aTime[w] = gTime[w] + ackDly[w] + 1;
            if (busyLen[w] < 1 || busyLen[w] > TMO) begin
                errT = aTime[w] + TMO;
                break;
            end
            eTime[w] = aTime[w] + busyLen[w];
        end
        if (errT < 0) doneT = eTime[NREG-1];
        endT = (errT >= 0) ? errT : doneT;
        tEnd = endT + 2;
        if (abortWord >= 0 && abortWord < nIssued && aTime[abortWord] >= 0)
            abortT = aTime[abortWord] + 2;

        ordyV  = new[tEnd + 1];
        startV = new[tEnd + 1];
        for (int t = 0; t <= tEnd; t++) begin
            ordyV[t]  = 1'b1;
            startV[t] = 1'b0;
        end
        startV[0] = 1'b1;
        for (int w = 0; w < nIssued; w++) begin
            if (aTime[w] >= 0) begin
                lowEnd = (eTime[w] >= 0) ? eTime[w] - 1 : tEnd;
                for (int t = aTime[w]; t <= lowEnd; t++) ordyV[t] = 1'b0;
            end
        end
        if (extraStarts) begin
            startV[2]        = 1'b1;
            startV[endT / 2] = 1'b1;
            startV[endT]     = 1'b1;
            startV[endT + 1] = 1'b1;
        end

        goSeen = 0; doneSeen = 0; errEnd = 1'b0; idxEnd = 4'd0;
        for (int t = 0; t <= tEnd; t++) begin
            applyStimulus(startV[t], ordyV[t]);
            expGo  = 1'b0;
            expIdx = 4'd0;
            expReg = modelReg;
            for (int w = 0; w < nIssued; w++) begin
                if (gTime[w] == t) expGo = 1'b1;
                if (w > 0 && t >= gTime[w] - 1) expIdx = 4'(w);
                if (t >= gTime[w]) expReg = romModel[w];
            end
            checkOutput($sformatf("%s cycle %0d", name, t), curOut(),
                        packOut(expGo, t < endT, doneT >= 0 && t == doneT,
                                errT >= 0 && t >= errT, expIdx, expReg));
            if (GO === 1'b1) begin
                if (goSeen >= 1 && goSeen < nIssued && eTime[goSeen-1] >= 0)
                    checkOutput($sformatf("%s gap before word %0d", name, goSeen),
                                24'(t - eTime[goSeen-1]), 24'(GAP + 1));
                goSeen++;
            end
            if (done === 1'b1) doneSeen++;
            errEnd   = err;
            idxEnd   = idx;
            modelReg = expReg;
            modelIdx = expIdx;
            modelErr = (errT >= 0 && t >= errT);
            if (t == abortT) break;
        end
        start = 1'b0;
        ORDY  = 1'b1;
    endtask

    initial begin
        int dlyArr [16];
        int lenArr [16];
        int goSeen, doneSeen;
        logic errEnd;
        logic [3:0] idxEnd;
        int hw, hk;

        vectors[0] = '{"normal",          1, 17, -1, 0, 1'b0, 8, 1, 0, 7};
        vectors[1] = '{"ack timeout w2",  1, 17,  2, 1, 1'b0, 3, 0, 1, 2};
        vectors[2] = '{"extra starts",    2,  5, -1, 0, 1'b1, 8, 1, 0, 7};
        vectors[3] = '{"done timeout w5", 3,  9,  5, 2, 1'b0, 6, 0, 1, 5};
        vectors[4] = '{"ack at limit w0", 1,  4,  0, 3, 1'b0, 8, 1, 0, 7};
        vectors[5] = '{"done at limit w7",1,  4,  7, 4, 1'b1, 8, 1, 0, 7};
        vectors[6] = '{"short busy",      1,  1, -1, 0, 1'b0, 8, 1, 0, 7};

        modelReg = 16'h0000; modelIdx = 4'd0; modelErr = 1'b0;

        // Reset state
        reset = 1'b0;
        start = 1'b0;
        ORDY  = 1'b1;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset values", curOut(), 24'h0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("idle after reset release", curOut(), 24'h0);

        // start while ORDY=0 must be ignored
        applyStimulus(1'b1, 1'b0);
        checkOutput("start with ORDY low", curOut(),
                    packOut(1'b0, 1'b0, 1'b0, modelErr, modelIdx, modelReg));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("stay idle %0d", i), curOut(),
                        packOut(1'b0, 1'b0, 1'b0, modelErr, modelIdx, modelReg));
        end
        applyStimulus(1'b0, 1'b1);

        // Table-driven scenarios
        for (int v = 0; v < 7; v++) begin
            $display("[TB] scenario %s", vectors[v].name);
            for (int w = 0; w < 16; w++) begin
                dlyArr[w] = vectors[v].dly;
                lenArr[w] = vectors[v].len;
                if (w == vectors[v].hangWord) begin
                    case (vectors[v].hangKind)
                        1: dlyArr[w] = -1;
                        2: lenArr[w] = -1;
                        3: dlyArr[w] = TMO;
                        4: lenArr[w] = TMO;
                        default: ;
                    endcase
                end
            end
            runSequence(vectors[v].name, dlyArr, lenArr, vectors[v].extraStarts, -1,
                        goSeen, doneSeen, errEnd, idxEnd);
            checkOutput({vectors[v].name, " GO count"}, 24'(goSeen), 24'(vectors[v].expGo));
            checkOutput({vectors[v].name, " done count"}, 24'(doneSeen), 24'(vectors[v].expDone));
            checkOutput({vectors[v].name, " err"}, 24'(errEnd), 24'(vectors[v].expErr));
            checkOutput({vectors[v].name, " idx"}, 24'(idxEnd), 24'(vectors[v].expIdx));
        end

        // Randomized spi_write behaviour against the timeline model
        for (int r = 0; r < 8; r++) begin
            hw = -1;
            hk = 0;
            if ($urandom_range(0, 3) == 0) begin
                hw = int'($urandom_range(0, NREG - 1));
                hk = int'($urandom_range(1, 2));
            end
            for (int w = 0; w < 16; w++) begin
                dlyArr[w] = int'($urandom_range(1, 6));
                lenArr[w] = int'($urandom_range(1, 30));
                if (w == hw && hk == 1) dlyArr[w] = -1;
                if (w == hw && hk == 2) lenArr[w] = -1;
            end
            runSequence($sformatf("random %0d", r), dlyArr, lenArr, bit'($urandom_range(0, 1)), -1,
                        goSeen, doneSeen, errEnd, idxEnd);
        end

        // Reset asserted during WAIT_DONE of word 5
        for (int w = 0; w < 16; w++) begin
            dlyArr[w] = 1;
            lenArr[w] = 17;
        end
        runSequence("abort run", dlyArr, lenArr, 1'b0, 5, goSeen, doneSeen, errEnd, idxEnd);
        reset = 1'b0;
        #1;
        checkOutput("async reset mid-run", curOut(), 24'h0);
        modelReg = 16'h0000; modelIdx = 4'd0; modelErr = 1'b0;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("held in reset", curOut(), 24'h0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, logic'($urandom_range(0, 1)));
            checkOutput($sformatf("no GO after reset %0d", i), curOut(), 24'h0);
        end
        applyStimulus(1'b0, 1'b1);
        runSequence("after reset", dlyArr, lenArr, 1'b0, -1, goSeen, doneSeen, errEnd, idxEnd);
        checkOutput("after reset GO count", 24'(goSeen), 24'd8);
        checkOutput("after reset done count", 24'(doneSeen), 24'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/spi_cfg_seq.md
SPI_CFG_SEQ -- requirements
Module: spi_cfg_seq

Interface
REQ-001 Parameter NUM_REGS, default 8: number of 16-bit configuration words sent per run (1..16).
REQ-002 Parameter GAP_CYCLES, default 4: idle CLK cycles between consecutive writes (0..255).
REQ-003 Parameter TIMEOUT, default 1024: maximum CLK cycles allowed per handshake phase before error.
REQ-004 CLK  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start  in  1  one-cycle pulse that begins a configuration run; ignored unless idle.
REQ-007 regdata  out  16  word presented to the downstream spi_write stage.
REQ-008 GO  out  1  one-cycle request pulse to spi_write.
REQ-009 ORDY  in  1  spi_write ready: 1 = idle/finished, 0 = transfer in progress.
REQ-010 busy  out  1  high from accepted start until DONE or ERR.
REQ-011 done  out  1  one-cycle pulse when all NUM_REGS words have completed.
REQ-012 err  out  1  sticky timeout flag, cleared only by the next accepted start or by reset.
REQ-013 idx  out  4  index of the word currently in flight.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, GAP, FIN, ERR.
REQ-015 IDLE: on start=1 and ORDY=1 -> LOAD, idx=0, err cleared, busy=1; start while ORDY=0 is ignored.
REQ-016 LOAD: regdata <= table[idx] (one-cycle registered ROM read) -> ISSUE.
REQ-017 ISSUE: GO=1 for exactly one cycle -> WAIT_ACK; regdata is stable from LOAD until leaving WAIT_DONE.
REQ-018 WAIT_ACK: wait for ORDY=0 -> WAIT_DONE; TIMEOUT cycles without it -> ERR.
REQ-019 WAIT_DONE: wait for ORDY=1 -> GAP, or -> FIN if idx==NUM_REGS-1; TIMEOUT cycles without it -> ERR.
REQ-020 GAP: count GAP_CYCLES cycles (0 = skip), then idx+1 -> LOAD.
REQ-021 FIN: done=1 one cycle, busy=0 -> IDLE.
REQ-022 ERR: err=1, busy=0, GO=0 -> IDLE in one cycle; err stays high in IDLE.
REQ-023 Timeout counter SHALL clear on each entry to WAIT_ACK and WAIT_DONE; an ORDY transition in the same cycle the count reaches TIMEOUT counts as success.
REQ-024 start during busy SHALL have no effect; at most one GO is outstanding.
REQ-025 idx SHALL never exceed NUM_REGS-1; no wrap occurs within a run.
REQ-026 Latency start -> first GO = 2 cycles (IDLE->LOAD->ISSUE).

Reset
REQ-027 While reset=0: state IDLE, regdata=16'h0000, GO=0, busy=0, done=0, err=0, idx=0, all counters 0.
REQ-028 Reset asserted mid-run SHALL abort immediately with no further GO; after release the block waits for a new start.

Structure
REQ-029 A shared package SHALL hold the state encoding, the default NUM_REGS/GAP_CYCLES/TIMEOUT values and the 16-bit word width.
REQ-030 The configuration table SHALL be a sub-module spi_cfg_rom (combinational, 4-bit address in, 16-bit word out); the sequencer registers its output.

Verification
REQ-031 Normal run: ROM words 16'hA8AA, 16'h1234, ... NUM_REGS=8; model spi_write with ORDY low 17 cycles after GO -> 8 GO pulses in order, regdata matches each word, one done pulse, err=0.
REQ-032 Gap check: GAP_CYCLES=4 -> exactly 4 cycles (plus LOAD) between ORDY rising and the next GO.
REQ-033 Timeout: ORDY held at 1 after the 3rd GO, TIMEOUT=1024 -> err=1 at cycle 1024 of WAIT_ACK, busy=0, no further GO, idx=2.
REQ-034 Start while busy: extra start pulses mid-run -> GO count still 8, single done.
REQ-035 Reset mid-run: reset=0 during WAIT_DONE of word 5 -> all outputs at reset values, no GO after release until start.
REQ-036 Start with ORDY=0 in IDLE -> ignored, busy stays 0.
